// File: rtl/cpu_instr_sequencer.sv
// Program sequencer for simple_cpu: issues one stored instruction at a time, each held for its opcode's cycle count.
// Latency: start to first instruction is 1 edge; abort to instruction=0 is 1 edge. No backpressure; the CPU consumes every cycle.
module cpu_instr_sequencer #(
    parameter int INSTR_WIDTH    = 20,
    parameter int PROG_ADDR_BITS = 4,
    parameter int ALU_HOLD       = 3,
    parameter int STORE_HOLD     = 3,
    parameter int LOAD_HOLD      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_we,
    input  logic [PROG_ADDR_BITS-1:0] prog_addr,
    input  logic [INSTR_WIDTH-1:0]    prog_data,
    input  logic                      start,
    input  logic                      abort,
    output logic [INSTR_WIDTH-1:0]    instruction,
    output logic                      issue,
    output logic [PROG_ADDR_BITS-1:0] pc,
    output logic                      busy,
    output logic                      done
);

    localparam int DEPTH = 1 << PROG_ADDR_BITS;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [INSTR_WIDTH-1:0]    mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0]    instr_q;
    logic [PROG_ADDR_BITS-1:0] pc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      issue_q;
    logic                      done_q;

    logic [PROG_ADDR_BITS-1:0] pc_inc;
    logic [INSTR_WIDTH-1:0]    mem_first;
    logic [INSTR_WIDTH-1:0]    mem_next;
    logic                      last_pc;

    // Hold count minus one, so a counter reaching zero marks the final cycle of an instruction.
    function automatic logic [CNT_W-1:0] hold_cnt(input logic [INSTR_WIDTH-1:0] instr);
        logic [1:0] op;
        op = instr[INSTR_WIDTH-1 -: 2];
        case (op)
            2'b01:   hold_cnt = CNT_W'(ALU_HOLD - 1);
            2'b10:   hold_cnt = CNT_W'(LOAD_HOLD - 1);
            2'b11:   hold_cnt = CNT_W'(STORE_HOLD - 1);
            default: hold_cnt = '0;
        endcase
    endfunction

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] instr);
        is_halt = (instr[INSTR_WIDTH-1 -: 2] == 2'b00);
    endfunction

    assign pc_inc    = pc_q + PROG_ADDR_BITS'(1);
    assign last_pc   = &pc_q;
    assign mem_first = mem_q[0];
    assign mem_next  = mem_q[pc_inc];

    // Writes are dropped while running so the executing program cannot change under the sequencer.
    always_ff @(posedge clk) begin
        if (rst && prog_we && (state_q != S_RUN)) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            issue_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            issue_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_halt(mem_first)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q    <= '0;
                            instr_q <= mem_first;
                            cnt_q   <= hold_cnt(mem_first);
                            issue_q <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        instr_q <= '0;
                        state_q <= S_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (last_pc || is_halt(mem_next)) begin
                        instr_q <= '0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        pc_q    <= pc_inc;
                        instr_q <= mem_next;
                        cnt_q   <= hold_cnt(mem_next);
                        issue_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign issue       = issue_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_RUN);
    assign done        = done_q;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Directed bench for cpu_instr_sequencer: program load, sequencing, hold timing, abort, reset and write protection.
module tb_cpu_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic        abort;
    logic [19:0] instruction;
    logic        issue;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    logic [19:0] full_prog [7] = '{20'h47000, 20'h53000, 20'h72001, 20'hD80F0,
                                   20'hCC160, 20'hB80F0, 20'h00000};
    int          full_hold [6] = '{3, 3, 3, 3, 3, 4};

    cpu_instr_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .abort      (abort),
        .instruction(instruction),
        .issue      (issue),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [19:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        tick();
        checks++;
        if (instruction !== 20'h0 || busy !== 1'b0 || done !== 1'b0 || pc !== 4'h0 || issue !== 1'b0) begin
            failures++;
            $display("FAIL reset: instr=%h busy=%b done=%b pc=%0d issue=%b, expected 0/0/0/0/0",
                     instruction, busy, done, pc, issue);
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_program();
        int issues;
        int busys;
        for (int i = 0; i < 7; i++) load_word(4'(i), full_prog[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        issues = 0;
        busys = 0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < full_hold[i]; j++) begin
                if (issue === 1'b1) issues++;
                if (busy === 1'b1) busys++;
                checks++;
                if (instruction !== full_prog[i] || pc !== 4'(i) || issue !== (j == 0)) begin
                    failures++;
                    $display("FAIL full_seq word%0d cycle%0d: instr=%h pc=%0d issue=%b, expected %h/%0d/%b",
                             i, j, instruction, pc, issue, full_prog[i], i, (j == 0));
                end
                tick();
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || instruction !== 20'h0 || pc !== 4'd5) begin
            failures++;
            $display("FAIL full_end: done=%b busy=%b instr=%h pc=%0d, expected 1/0/00000/5",
                     done, busy, instruction, pc);
        end
        checks++;
        if (issues !== 6 || busys !== 19) begin
            failures++;
            $display("FAIL full_counts: issues=%0d busy_cycles=%0d, expected 6/19", issues, busys);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_done_pulse: done=%b busy=%b, expected 0/0", done, busy);
        end
    endtask

    task automatic test_empty_program();
        load_word(4'd0, 20'h00000);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || instruction !== 20'h0 || issue !== 1'b0) begin
            failures++;
            $display("FAIL empty_start: done=%b busy=%b instr=%h issue=%b, expected 1/0/00000/0",
                     done, busy, instruction, issue);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_after: done=%b busy=%b, expected 0/0", done, busy);
        end
    endtask

    task automatic test_full_store();
        int busys;
        for (int i = 0; i < 16; i++) load_word(4'(i), 20'h40000 | 20'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        busys = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (busy === 1'b1) busys++;
                checks++;
                if (pc !== 4'(i) || instruction !== (20'h40000 | 20'(i))) begin
                    failures++;
                    $display("FAIL store_seq addr%0d cycle%0d: pc=%0d instr=%h, expected %0d/%h",
                             i, j, pc, instruction, i, 20'h40000 | 20'(i));
                end
                tick();
            end
        end
        checks++;
        if (busys !== 48 || done !== 1'b1 || pc !== 4'd15) begin
            failures++;
            $display("FAIL store_end: busy_cycles=%0d done=%b pc=%0d, expected 48/1/15", busys, done, pc);
        end
        tick();
        checks++;
        if (pc !== 4'd15 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL store_nowrap: pc=%0d busy=%b done=%b, expected 15/0/0", pc, busy, done);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 7; i++) load_word(4'(i), full_prog[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (pc !== 4'd1 || issue !== 1'b1 || instruction !== 20'h53000) begin
            failures++;
            $display("FAIL abort_pre: pc=%0d issue=%b instr=%h, expected 1/1/53000", pc, issue, instruction);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (instruction !== 20'h0 || busy !== 1'b0 || done !== 1'b0 || issue !== 1'b0) begin
            failures++;
            $display("FAIL abort_edge: instr=%h busy=%b done=%b issue=%b, expected 00000/0/0/0",
                     instruction, busy, done, issue);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_nodone: done=%b busy=%b, expected 0/0", done, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        abort = 1'b1;
        prog_we = 1'b1;
        prog_addr = 4'd0;
        prog_data = 20'h12345;
        tick();
        rst = 1'b1;
        abort = 1'b0;
        prog_we = 1'b0;
        checks++;
        if (busy !== 1'b0 || instruction !== 20'h0 || pc !== 4'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b instr=%h pc=%0d done=%b, expected 0/00000/0/0",
                     busy, instruction, pc, done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (instruction !== 20'h47000 || busy !== 1'b1 || issue !== 1'b1) begin
            failures++;
            $display("FAIL reset_blocks_write: instr=%h busy=%b issue=%b, expected 47000/1/1",
                     instruction, busy, issue);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_write_protect();
        int n;
        load_word(4'd0, 20'h4A000);
        load_word(4'd1, 20'h00000);
        start = 1'b1;
        tick();
        start = 1'b0;
        prog_we = 1'b1;
        prog_addr = 4'd0;
        prog_data = 20'h80000;
        tick();
        prog_we = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wp_run1_done: done=%b after %0d cycles, expected 1", done, n);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (instruction !== 20'h4A000) begin
            failures++;
            $display("FAIL wp_rerun: instr=%h, expected 4a000", instruction);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wp_run2_done: done=%b after %0d cycles, expected 1", done, n);
        end
        tick();
        start = 1'b1;
        prog_we = 1'b1;
        prog_addr = 4'd0;
        prog_data = 20'h5B000;
        tick();
        start = 1'b0;
        prog_we = 1'b0;
        checks++;
        if (instruction !== 20'h4A000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL collide_old: instr=%h busy=%b, expected 4a000/1", instruction, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL collide_done: done=%b after %0d cycles, expected 1", done, n);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (instruction !== 20'h5B000 || issue !== 1'b1) begin
            failures++;
            $display("FAIL collide_new: instr=%h issue=%b, expected 5b000/1", instruction, issue);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start = 1'b0;
        abort = 1'b0;
        test_reset();
        test_full_program();
        test_empty_program();
        test_full_store();
        test_abort();
        test_reset_mid_run();
        test_write_protect();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_instr_sequencer.md
# cpu_instr_sequencer

Program sequencer that issues 20-bit instructions to `simple_cpu`, taking over the instruction-driving role the bench performs today. It holds a small loadable program store and a program counter, and presents one instruction at a time on the CPU's `instruction` input. Each instruction is held for a fixed number of cycles set by its opcode class, then the next one is issued. Sits between a host/bench program-load port and `simple_cpu`.

## Interface
Parameters:
- `INSTR_WIDTH`, 20: instruction width; must match `simple_cpu`.
- `PROG_ADDR_BITS`, 4: program store depth is 2^PROG_ADDR_BITS (16 entries).
- `ALU_HOLD`, 3: cycles an ALU instruction (opcode 01) is held; must be ≥1.
- `STORE_HOLD`, 3: cycles a STORE_R instruction (opcode 11) is held; must be ≥1.
- `LOAD_HOLD`, 4: cycles a LOAD_R instruction (opcode 10) is held; must be ≥1.

Ports:
- `clk`, in, 1: single clock; everything updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `prog_we`, in, 1: program-store write enable.
- `prog_addr`, in, PROG_ADDR_BITS: write address.
- `prog_data`, in, INSTR_WIDTH: write data.
- `start`, in, 1: begin executing at address 0; sampled only in IDLE.
- `abort`, in, 1: stop a running program immediately.
- `instruction`, out, INSTR_WIDTH: instruction to `simple_cpu`; registered.
- `issue`, out, 1: one-cycle pulse, high in the first cycle a new instruction is valid.
- `pc`, out, PROG_ADDR_BITS: address of the instruction currently on `instruction`.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse on normal completion.

## Operation
- Opcode is `instruction[19:18]`: 00 HALT, 01 ALU (ADD/SUB), 10 LOAD_R, 11 STORE_R. The hold count H(op) is the matching parameter.
- Program store is a register array, written synchronously when `prog_we`=1 and the state is not RUN. Reads are asynchronous. Reset does not clear it.
- States are IDLE, RUN and DONE.
- **IDLE**, with `start`=1:
  - If mem[0] is HALT: go to DONE; `instruction` stays 0.
  - Otherwise: `pc`←0, `instruction`←mem[0], cnt←H−1, `issue`←1, go to RUN.
- **RUN**:
  - If `abort`=1: `instruction`←0 and go to IDLE; `done` is not pulsed. `abort` has priority over everything else.
  - Else if cnt≠0: cnt←cnt−1.
  - Else, when `pc` is the last address or mem[pc+1] is HALT: `instruction`←0 and go to DONE.
  - Else: `pc`←pc+1, `instruction`←mem[pc+1], cnt←H(new)−1, `issue`←1.
- **DONE**: `done`=1 for one cycle, then go to IDLE. `pc` keeps its last value.
- `start` is ignored in RUN and DONE. `abort` is ignored outside RUN.
- `prog_we` is ignored while in RUN; the write is dropped.
- `start` and `prog_we` in the same IDLE cycle: the write completes, but the issue reads the pre-write contents.
- There is no `pc` wrap-around: the last address ends the program.

## Timing
- Reset (`rst`=0 at an edge) forces:
  - state IDLE;
  - `instruction`=0, `pc`=0, cnt=0;
  - `busy`=0, `issue`=0, `done`=0.
- Reset applies even mid-RUN and overrides `start`, `abort` and `prog_we`.
- `start` is sampled at edge E0. The first instruction is valid from E0 until E0+H; there is no bubble between instructions.
- Each instruction is stable on `instruction` for exactly H(op) cycles.
- `issue` is high in the first of those cycles only.
- `busy` is high from E0 to the edge that leaves RUN, i.e. for ΣH cycles.
- `done` is high in the single cycle after RUN ends.
- Latency from `start` to the first instruction is 1 edge. Latency from `abort` to `instruction`=0 is 1 edge.

## Test plan
- **Reset:** drive `rst`=0 with `start`=1 → `instruction`=0, `busy`=0, `done`=0, `pc`=0 after the edge.
- **Full program:** load 0x47000, 0x53000, 0x72001, 0xD80F0, 0xCC160, 0xB80F0, 0x00000 at addresses 0–6, then pulse `start`.
  - Each word is held for 3, 3, 3, 3, 3 and 4 cycles respectively.
  - 6 `issue` pulses.
  - `busy` is high for 19 cycles, then one `done` pulse.
  - Connected to `simple_cpu`, the final registers are 4, 7, 2, 7.
- **Empty program:** mem[0]=0 → `done` pulses in the cycle after `start`; `busy` never rises.
- **Full store:** all 16 entries are ALU → `pc` steps 0…15 with 48 `busy` cycles; `done` follows; `pc` stays 15 with no wrap.
- **Abort:** assert `abort` in the 2nd cycle of address 1 → `instruction`=0 and `busy`=0 at the next edge; no `done`.
- **Write protection and collision:**
  - `prog_we` during RUN → the store is unchanged (read back on a rerun).
  - `start` and `prog_we` to address 0 in the same cycle → the old mem[0] is issued.
